// File: rtl/csr_unpack.sv
// CSR frame unpacker: captures one 35-word CSR frame, validates row counts, streams (row, col, value) tuples.
// Latency: word 34 stored at T -> CHECK at T+1 -> first tuple (or done for empty/error frames) at T+2.
// Backpressure: out_valid/out_ready; tuple fields hold while stalled; one tuple per cycle when out_ready is high.
//
// Ports:
//   clk, rst        single rising-edge clock, synchronous active-high reset
//   start           one-cycle pulse, honoured only when idle; clears err
//   in_req          high throughout frame load (upstream read enable)
//   in_valid/in_data  frame words, accepted only while loading
//   out_valid/out_ready, out_row/out_col/out_val/out_last  tuple stream
//   busy, done, err   status: not idle / end-of-frame pulse / sticky frame reject
module csr_unpack #(
    parameter int N           = 16,
    parameter int MAX_NNZ     = 64,
    parameter int FRAME_WORDS = 35
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        in_req,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_row,
    output logic [3:0]  out_col,
    output logic [7:0]  out_val,
    output logic        out_last,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int WCW = $clog2(FRAME_WORDS);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(FRAME_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_EMIT,
        S_DONE
    } state_t;

    state_t          state;
    logic [WCW-1:0]  wc;
    logic [5:0]      e;      // element index of the tuple currently presented
    logic [3:0]      row;    // row of the tuple currently presented
    logic [4:0]      rem;    // elements left in the current row, including the presented one

    logic [31:0]     mem [FRAME_WORDS];

    // Frame storage is not reset; a new frame always overwrites all 35 words before use.
    always_ff @(posedge clk) begin
        if (state == S_LOAD && in_valid) begin
            mem[wc] <= in_data;
        end
    end

    // Row counts decoded from the 80 meaningful bits of words 32..34.
    logic [79:0]  rc_bits;
    logic [4:0]   cnt [N];
    logic [N-1:0] nz_mask;
    logic [8:0]   nnz_sum;   // wide enough that bad counts cannot wrap into a legal total
    logic         cnt_ovf;

    assign rc_bits = {mem[34][15:0], mem[33], mem[32]};

    always_comb begin
        nz_mask = '0;
        nnz_sum = '0;
        cnt_ovf = 1'b0;
        for (int r = 0; r < N; r++) begin
            cnt[r]     = rc_bits[5*r +: 5];
            nz_mask[r] = |cnt[r];
            nnz_sum    = nnz_sum + 9'(cnt[r]);
            if (cnt[r] > 5'd16) begin
                cnt_ovf = 1'b1;
            end
        end
    end

    function automatic logic [3:0] lowest_row(input logic [N-1:0] m);
        logic [3:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

    // Next tuple to present: either the first one (from CHECK) or the successor of the
    // current one. Exhausted rows jump straight to the next nonzero row so empty rows
    // cost no cycles.
    logic [5:0]   e_nx;
    logic [3:0]   row_nx;
    logic [4:0]   rem_nx;
    logic [N-1:0] above_mask;
    logic [5:0]   vw_idx;
    logic [5:0]   cw_idx;
    logic [7:0]   val_nx;
    logic [3:0]   col_nx;
    logic         last_nx;

    always_comb begin
        above_mask = nz_mask & (({N{1'b1}} << row) << 1);
        if (state == S_CHECK) begin
            e_nx   = '0;
            row_nx = lowest_row(nz_mask);
            rem_nx = cnt[row_nx];
        end else if (rem == 5'd1) begin
            e_nx   = e + 6'd1;
            row_nx = lowest_row(above_mask);
            rem_nx = cnt[row_nx];
        end else begin
            e_nx   = e + 6'd1;
            row_nx = row;
            rem_nx = rem - 5'd1;
        end
        vw_idx  = {2'b00, e_nx[5:2]};
        cw_idx  = 6'd16 + {2'b00, e_nx[5:2]};
        val_nx  = mem[vw_idx][{e_nx[1:0], 3'b000} +: 8];
        col_nx  = mem[cw_idx][{e_nx[1:0], 3'b000} +: 4];
        last_nx = ({3'b000, e_nx} == (nnz_sum - 9'd1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wc        <= '0;
            e         <= '0;
            row       <= '0;
            rem       <= '0;
            in_req    <= 1'b0;
            out_valid <= 1'b0;
            out_row   <= '0;
            out_col   <= '0;
            out_val   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_LOAD;
                        wc     <= '0;
                        in_req <= 1'b1;
                        busy   <= 1'b1;
                        err    <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        wc <= wc + WCW'(1);
                        if (wc == LAST_WORD) begin
                            state  <= S_CHECK;
                            in_req <= 1'b0;
                        end
                    end
                end
                S_CHECK: begin
                    if (cnt_ovf || (nnz_sum > 9'(MAX_NNZ))) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (nnz_sum == 9'd0) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state     <= S_EMIT;
                        out_valid <= 1'b1;
                        e         <= e_nx;
                        row       <= row_nx;
                        rem       <= rem_nx;
                        out_row   <= row_nx;
                        out_col   <= col_nx;
                        out_val   <= val_nx;
                        out_last  <= last_nx;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            e        <= e_nx;
                            row      <= row_nx;
                            rem      <= rem_nx;
                            out_row  <= row_nx;
                            out_col  <= col_nx;
                            out_val  <= val_nx;
                            out_last <= last_nx;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csr_unpack.sv
// Bench for csr_unpack: directed frames, expected tuples queued by the stimulus, checked by a monitor.
// Monitor samples on the falling edge; stimulus drives 1 time unit after the rising edge.
// out_ready is driven by its own process: held high or randomly toggled per frame.
module tb_csr_unpack;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_req;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_row;
    logic [3:0]  out_col;
    logic [7:0]  out_val;
    logic        out_last;
    logic        busy;
    logic        done;
    logic        err;

    csr_unpack #(.N(16), .MAX_NNZ(64), .FRAME_WORDS(35)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_req    (in_req),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_val   (out_val),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
        logic [7:0] val;
        logic       last;
    } tup_t;

    tup_t        exp_q [$];
    int          checks;
    int          errors;
    int          acc_count;
    int          rdy_mode;
    bit          mon_en;

    logic [31:0] frame [35];
    logic [4:0]  f_cnt [16];
    logic [7:0]  f_val [64];
    logic [7:0]  f_col [64];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (time=%0t, required earlier)", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [3:0] r, input logic [3:0] c, input logic [7:0] v, input logic l);
        tup_t t;
        t.row  = r;
        t.col  = c;
        t.val  = v;
        t.last = l;
        exp_q.push_back(t);
    endtask

    // out_ready driver: mode 0 = always high, mode 1 = random per cycle.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
            else               out_ready = 1'b1;
        end
    end

    // Monitor / scoreboard.
    initial begin
        tup_t cur;
        tup_t held;
        tup_t t;
        bit   stall_prev;
        bit   done_next;
        stall_prev = 0;
        done_next  = 0;
        held       = '0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                stall_prev = 0;
                done_next  = 0;
            end else begin
                if (done_next) begin
                    check("done_after_last", 32'(done), 32'd1);
                    done_next = 0;
                end
                cur = {out_row, out_col, out_val, out_last};
                if (stall_prev) begin
                    check("stall_valid_hold", 32'(out_valid), 32'd1);
                    check("stall_fields_hold", 32'(cur), 32'(held));
                end
                stall_prev = out_valid && !out_ready;
                held = cur;
                if (out_valid && exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tuple actual=%0h expected=no tuple", cur);
                end else if (out_valid && out_ready) begin
                    t = exp_q.pop_front();
                    check("tuple", 32'(cur), 32'(t));
                    acc_count++;
                    if (t.last) done_next = 1;
                end
            end
        end
    end

    task automatic clear_frame();
        for (int i = 0; i < 16; i++) f_cnt[i] = '0;
        for (int i = 0; i < 64; i++) begin
            f_val[i] = '0;
            f_col[i] = '0;
        end
    endtask

    task automatic pack_frame();
        logic [95:0] rbits;
        rbits = '0;
        for (int i = 0; i < 35; i++) frame[i] = '0;
        for (int i = 0; i < 64; i++) begin
            frame[i/4][8*(i%4) +: 8]      = f_val[i];
            frame[16 + i/4][8*(i%4) +: 8] = f_col[i];
        end
        for (int r = 0; r < 16; r++) rbits[5*r +: 5] = f_cnt[r];
        frame[32] = rbits[31:0];
        frame[33] = rbits[63:32];
        frame[34] = rbits[95:64];
    endtask

    task automatic setup_diag();
        clear_frame();
        for (int r = 0; r < 16; r++) begin
            f_cnt[r] = 5'd1;
            f_col[r] = 8'(r);
            f_val[r] = 8'(r + 1);
        end
        pack_frame();
        for (int r = 0; r < 16; r++) push_exp(4'(r), 4'(r), 8'(r + 1), r == 15);
    endtask

    task automatic load_frame();
        @(posedge clk);
        #1;
        start    = 1'b1;
        in_valid = 1'b1;             // junk while idle, must be ignored
        in_data  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("start_to_in_req", 32'(in_req), 32'd1);
        check("err_cleared_on_start", 32'(err), 32'd0);
        check("busy_in_load", 32'(busy), 32'd1);
        for (int i = 0; i < 35; i++) begin
            if (i == 5) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = frame[i];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("in_req_low_after_load", 32'(in_req), 32'd0);
    endtask

    task automatic run_frame(input int n, input logic exp_err, input int rmode);
        int k;
        bit got;
        rdy_mode = rmode;
        load_frame();
        check("check_cycle_out_valid", 32'(out_valid), 32'd0);
        check("check_cycle_done", 32'(done), 32'd0);
        in_valid = 1'b1;             // outside LOAD, must be ignored
        in_data  = 32'hFFFF_FFFF;
        got = 0;
        k   = 0;
        for (int i = 1; i <= 3000; i++) begin
            if (i == 2 && n >= 4) start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            if (i == 1) check("first_out_valid_T2", 32'(out_valid), 32'(n > 0));
            if (done) begin
                got = 1;
                k   = i;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no done expected=done within 3000 cycles");
        end else begin
            check("err_at_done", 32'(err), 32'(exp_err));
            if (rmode == 0) check("done_cycle", 32'(k), 32'(n + 1));
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_one_cycle", 32'(done), 32'd0);
        check("err_sticky", 32'(err), 32'(exp_err));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_req"}, 32'(in_req), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_fields"}, 32'({out_row, out_col, out_val, out_last}), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int acc0;
        checks    = 0;
        errors    = 0;
        acc_count = 0;
        rdy_mode  = 0;
        mon_en    = 1;
        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Diagonal: (r, r, r+1), back to back.
        setup_diag();
        run_frame(16, 1'b0, 0);

        // Sparse rows 0,0,5,15 with empty rows skipped; junk in ignored R[95:80].
        clear_frame();
        f_cnt[0] = 5'd2;  f_cnt[5] = 5'd1;  f_cnt[15] = 5'd1;
        f_val[0] = 8'h7F; f_val[1] = 8'h80; f_val[2] = 8'h01; f_val[3] = 8'hFF;
        f_col[0] = 8'h03; f_col[1] = 8'h09; f_col[2] = 8'h00; f_col[3] = 8'h0F;
        pack_frame();
        frame[34][31:16] = 16'hBEEF;
        push_exp(4'd0,  4'd3,  8'h7F, 1'b0);
        push_exp(4'd0,  4'd9,  8'h80, 1'b0);
        push_exp(4'd5,  4'd0,  8'h01, 1'b0);
        push_exp(4'd15, 4'd15, 8'hFF, 1'b1);
        run_frame(4, 1'b0, 0);

        // Full frame, random backpressure; col bytes carry junk in [7:4].
        clear_frame();
        for (int r = 0; r < 4; r++) f_cnt[r] = 5'd16;
        for (int i = 0; i < 64; i++) begin
            f_col[i] = 8'hA0 | 8'((i * 5 + 3) % 16);
            f_val[i] = 8'((i * 3 + 1) % 256);
        end
        pack_frame();
        for (int i = 0; i < 64; i++) push_exp(4'(i / 16), 4'((i * 5 + 3) % 16), 8'((i * 3 + 1) % 256), i == 63);
        run_frame(64, 1'b0, 1);

        // Empty frame.
        clear_frame();
        pack_frame();
        run_frame(0, 1'b0, 0);

        // Single count of 17.
        clear_frame();
        f_cnt[0] = 5'd17;
        pack_frame();
        run_frame(0, 1'b1, 0);
        repeat (3) @(posedge clk);
        #1;
        check("err_held_while_idle", 32'(err), 32'd1);

        // Counts all legal but total 65.
        clear_frame();
        for (int r = 0; r < 4; r++) f_cnt[r] = 5'd16;
        f_cnt[4] = 5'd1;
        pack_frame();
        run_frame(0, 1'b1, 0);

        // Reset in the middle of EMIT after 10 accepted tuples.
        setup_diag();
        rdy_mode = 0;
        acc0 = acc_count;
        load_frame();
        for (int i = 0; i < 200; i++) begin
            if (acc_count - acc0 >= 10) break;
            @(posedge clk);
        end
        check("mid_emit_10_accepted", 32'(acc_count - acc0 >= 10), 32'd1);
        #1;
        rst    = 1'b1;
        mon_en = 0;
        @(posedge clk);
        #1;
        check_all_zero("mid_emit_reset");
        rst = 1'b0;
        exp_q.delete();
        mon_en = 1;

        setup_diag();
        run_frame(16, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
